// File: rtl/source_streamer_pkg.sv
// Shared types and character constants for the assembler text streamer.
package source_streamer_pkg;

  typedef enum logic [1:0] {
    ASM_IDLE            = 2'd0,
    PC_MAPPING          = 2'd1,
    INSTRUCTION_MAPPING = 2'd2,
    ASM_DONE            = 2'd3
  } assembler_state_t;

  localparam logic [7:0] ASCII_NL  = 8'h0A;
  localparam logic [7:0] ASCII_NUL = 8'h00;

endpackage

// File: rtl/source_streamer_imem_writer.sv
// Captures finished instructions from the assembler and writes them to
// consecutive instruction-memory words, counting how many were written.
module imem_writer
  import source_streamer_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clear,
  input  logic          i_en,
  input  logic          i_done,
  input  logic [31:0]   i_instr,
  output logic          o_we,
  output logic [AW-1:0] o_addr,
  output logic [31:0]   o_data,
  output logic [AW:0]   o_count
);

  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_data;
  logic [AW:0]   r_count;
  logic [AW:0]   w_next_idx;

  // the count lags a write by one cycle, so fold an in-flight write into the next address
  assign w_next_idx = r_count + {{AW{1'b0}}, r_we};

  // capture one instruction per assembler done pulse
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_we   <= 1'b0;
      r_addr <= {AW{1'b0}};
      r_data <= 32'h0000_0000;
    end else if (i_clear) begin
      r_we   <= 1'b0;
      r_addr <= {AW{1'b0}};
      r_data <= 32'h0000_0000;
    end else if (i_en && i_done) begin
      r_we   <= 1'b1;
      r_addr <= w_next_idx[AW-1:0];
      r_data <= i_instr;
    end else begin
      r_we   <= 1'b0;
      r_addr <= r_addr;
      r_data <= r_data;
    end
  end

  // instruction counter, advanced after each write strobe
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= {(AW+1){1'b0}};
    end else if (i_clear) begin
      r_count <= {(AW+1){1'b0}};
    end else if (r_we) begin
      r_count <= r_count + {{AW{1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  assign o_we    = r_we;
  assign o_addr  = r_addr;
  assign o_data  = r_data;
  assign o_count = r_count;

endmodule

// File: rtl/source_streamer.sv
// Streams program text from the text BRAM to the assembler, one character at a
// time, over two passes, and writes the resulting instructions to memory.
module source_streamer
  import source_streamer_pkg::*;
#(
  parameter int CHAR_PER_LINE = 64,
  parameter int NUMBER_LINES  = 256,
  parameter int READ_LATENCY  = 2,
  parameter int LINE_GAP      = 4
) (
  input  logic                                          clk_in,
  input  logic                                          rst_in,
  input  logic                                          start_in,
  output logic [$clog2(NUMBER_LINES*CHAR_PER_LINE)-1:0] text_addr_out,
  input  logic [7:0]                                    text_data_in,
  output logic                                          new_line,
  output logic                                          new_character,
  output logic [$clog2(NUMBER_LINES)-1:0]               line_count,
  output logic [$clog2(CHAR_PER_LINE)-1:0]              char_count,
  output logic [7:0]                                    incoming_character,
  output assembler_state_t                              assembler_state,
  input  logic                                          asm_done_in,
  input  logic                                          asm_error_in,
  input  logic [31:0]                                   asm_instruction_in,
  output logic                                          imem_we_out,
  output logic [$clog2(NUMBER_LINES)-1:0]               imem_addr_out,
  output logic [31:0]                                   imem_data_out,
  output logic                                          busy_out,
  output logic                                          error_out,
  output logic [$clog2(NUMBER_LINES)-1:0]               error_line_out,
  output logic [$clog2(NUMBER_LINES):0]                 inst_count_out
);

  localparam int LW   = $clog2(NUMBER_LINES);
  localparam int CW   = $clog2(CHAR_PER_LINE);
  localparam int AW   = $clog2(NUMBER_LINES*CHAR_PER_LINE);
  localparam int LATW = $clog2(READ_LATENCY+1);
  localparam int GW   = $clog2(LINE_GAP+1);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_LINE     = 4'd1,
    S_FETCH    = 4'd2,
    S_WAIT     = 4'd3,
    S_EMIT     = 4'd4,
    S_GAP      = 4'd5,
    S_PASS_END = 4'd6,
    S_DONE     = 4'd7,
    S_ERROR    = 4'd8
  } state_t;

  state_t           r_state,     w_state;
  logic [LW-1:0]    r_line,      w_line;
  logic [CW-1:0]    r_char,      w_char;
  logic [LATW-1:0]  r_lat,       w_lat;
  logic [GW-1:0]    r_gap,       w_gap;
  logic [AW-1:0]    r_addr,      w_addr;
  logic             r_new_line,  w_new_line;
  logic             r_new_char,  w_new_char;
  logic [7:0]       r_inc,       w_inc;
  logic [7:0]       r_raw,       w_raw;
  assembler_state_t r_asm_state, w_asm_state;
  logic             r_busy,      w_busy;
  logic             r_err,       w_err;
  logic [LW-1:0]    r_err_line,  w_err_line;
  logic             w_clear;
  logic             w_active;
  logic             w_wr_en;

  assign w_active = (r_state == S_LINE) || (r_state == S_FETCH) || (r_state == S_WAIT) ||
                    (r_state == S_EMIT) || (r_state == S_GAP)   || (r_state == S_PASS_END);

  // next-state and next-output logic; pulses and the character are decided one cycle
  // ahead so that every output leaves a register
  always_comb begin
    w_state     = r_state;
    w_line      = r_line;
    w_char      = r_char;
    w_lat       = r_lat;
    w_gap       = r_gap;
    w_addr      = r_addr;
    w_new_line  = 1'b0;
    w_new_char  = 1'b0;
    w_inc       = r_inc;
    w_raw       = r_raw;
    w_asm_state = r_asm_state;
    w_busy      = r_busy;
    w_err       = r_err;
    w_err_line  = r_err_line;
    w_clear     = 1'b0;
    if (w_active && asm_error_in) begin
      w_state     = S_ERROR;
      w_err       = 1'b1;
      w_err_line  = r_line;
      w_busy      = 1'b0;
      w_asm_state = ASM_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start_in) begin
            w_state     = S_LINE;
            w_line      = LW'(0);
            w_char      = CW'(0);
            w_asm_state = PC_MAPPING;
            w_busy      = 1'b1;
            w_err       = 1'b0;
            w_err_line  = LW'(0);
            w_new_line  = 1'b1;
            w_clear     = 1'b1;
          end else begin
            w_state = r_state;
          end
        end
        S_LINE: begin
          w_state = S_FETCH;
          w_addr  = {r_line, r_char};
        end
        S_FETCH: begin
          w_state = S_WAIT;
          w_lat   = LATW'(READ_LATENCY-1);
        end
        S_WAIT: begin
          if (r_lat == LATW'(0)) begin
            w_state    = S_EMIT;
            w_raw      = text_data_in;
            w_new_char = !((text_data_in == ASCII_NUL) && (r_char == CW'(0)));
            w_inc      = (text_data_in == ASCII_NUL) ? ASCII_NL : text_data_in;
          end else begin
            w_lat = r_lat - LATW'(1);
          end
        end
        S_EMIT: begin
          if ((r_raw == ASCII_NUL) && (r_char == CW'(0))) begin
            w_state = S_PASS_END;
          end else if ((r_raw == ASCII_NUL) || (r_raw == ASCII_NL) ||
                       (r_char == CW'(CHAR_PER_LINE-1))) begin
            w_state = S_GAP;
            w_gap   = GW'(LINE_GAP-1);
          end else begin
            w_state = S_FETCH;
            w_char  = r_char + CW'(1);
            w_addr  = {r_line, w_char};
          end
        end
        S_GAP: begin
          if (r_gap != GW'(0)) begin
            w_gap = r_gap - GW'(1);
          end else if (r_line == LW'(NUMBER_LINES-1)) begin
            w_state = S_PASS_END;
          end else begin
            w_state    = S_LINE;
            w_line     = r_line + LW'(1);
            w_char     = CW'(0);
            w_new_line = 1'b1;
          end
        end
        S_PASS_END: begin
          if (r_asm_state == PC_MAPPING) begin
            w_state     = S_LINE;
            w_asm_state = INSTRUCTION_MAPPING;
            w_line      = LW'(0);
            w_char      = CW'(0);
            w_new_line  = 1'b1;
          end else begin
            w_state     = S_DONE;
            w_asm_state = ASM_DONE;
            w_busy      = 1'b0;
          end
        end
        default: begin
          w_state = S_IDLE;
        end
      endcase
    end
  end

  // state and output registers
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state     <= S_IDLE;
      r_line      <= LW'(0);
      r_char      <= CW'(0);
      r_lat       <= LATW'(0);
      r_gap       <= GW'(0);
      r_addr      <= AW'(0);
      r_new_line  <= 1'b0;
      r_new_char  <= 1'b0;
      r_inc       <= 8'h00;
      r_raw       <= 8'h00;
      r_asm_state <= ASM_IDLE;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_err_line  <= LW'(0);
    end else begin
      r_state     <= w_state;
      r_line      <= w_line;
      r_char      <= w_char;
      r_lat       <= w_lat;
      r_gap       <= w_gap;
      r_addr      <= w_addr;
      r_new_line  <= w_new_line;
      r_new_char  <= w_new_char;
      r_inc       <= w_inc;
      r_raw       <= w_raw;
      r_asm_state <= w_asm_state;
      r_busy      <= w_busy;
      r_err       <= w_err;
      r_err_line  <= w_err_line;
    end
  end

  // writes happen only while the second pass is live and no error is being raised
  assign w_wr_en = (r_asm_state == INSTRUCTION_MAPPING) && !asm_error_in;

  imem_writer #(
    .AW (LW)
  ) u_imem_writer (
    .i_clk   (clk_in),
    .i_rst_n (rst_in),
    .i_clear (w_clear),
    .i_en    (w_wr_en),
    .i_done  (asm_done_in),
    .i_instr (asm_instruction_in),
    .o_we    (imem_we_out),
    .o_addr  (imem_addr_out),
    .o_data  (imem_data_out),
    .o_count (inst_count_out)
  );

  assign text_addr_out      = r_addr;
  assign new_line           = r_new_line;
  assign new_character      = r_new_char;
  assign line_count         = r_line;
  assign char_count         = r_char;
  assign incoming_character = r_inc;
  assign assembler_state    = r_asm_state;
  assign busy_out           = r_busy;
  assign error_out          = r_err;
  assign error_line_out     = r_err_line;

endmodule

// File: tb/tb_source_streamer.sv
// Directed bench for source_streamer: BRAM model, assembler stub and per-scenario tasks.
module tb_source_streamer;
  import source_streamer_pkg::*;

  localparam int RL = 2;

  logic             clk_in = 1'b0;
  logic             rst_in = 1'b0;
  logic             start_in = 1'b0;
  logic [13:0]      text_addr_out;
  logic [7:0]       text_data_in;
  logic             new_line, new_character;
  logic [7:0]       line_count;
  logic [5:0]       char_count;
  logic [7:0]       incoming_character;
  assembler_state_t assembler_state;
  logic             asm_done_in = 1'b0, asm_error_in = 1'b0;
  logic [31:0]      asm_instruction_in = 32'h0;
  logic             imem_we_out;
  logic [7:0]       imem_addr_out;
  logic [31:0]      imem_data_out;
  logic             busy_out, error_out;
  logic [7:0]       error_line_out;
  logic [8:0]       inst_count_out;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [0:16383];
  logic [7:0]  rd_pipe [0:RL-1];
  bit          has_instr [0:255];
  logic [31:0] instr_tab [0:255];

  int          nl_cnt [4];
  int          nc_cnt [4];
  int          wr_n, first_gap, max_cc0, char_mis, overlap, dist_bad;
  logic [7:0]  last_char;
  logic [7:0]  wr_addr [16];
  logic [31:0] wr_data [16];
  int          nl_seq [$];
  bit          timeout;

  source_streamer dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
    .text_addr_out(text_addr_out), .text_data_in(text_data_in),
    .new_line(new_line), .new_character(new_character),
    .line_count(line_count), .char_count(char_count),
    .incoming_character(incoming_character), .assembler_state(assembler_state),
    .asm_done_in(asm_done_in), .asm_error_in(asm_error_in),
    .asm_instruction_in(asm_instruction_in),
    .imem_we_out(imem_we_out), .imem_addr_out(imem_addr_out), .imem_data_out(imem_data_out),
    .busy_out(busy_out), .error_out(error_out), .error_line_out(error_line_out),
    .inst_count_out(inst_count_out)
  );

  always #5 clk_in = ~clk_in;

  // text BRAM: registered read pipeline of depth RL
  always @(posedge clk_in) begin
    rd_pipe[0] <= mem[text_addr_out];
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign text_data_in = rd_pipe[RL-1];

  task automatic clear_mem();
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    for (int i = 0; i < 256; i++) begin
      has_instr[i] = 1'b0;
      instr_tab[i] = 32'h0;
    end
  endtask

  task automatic load_line(input int ln, input string s);
    for (int i = 0; i < s.len(); i++) mem[ln*64 + i] = s[i];
  endtask

  task automatic pulse_start();
    @(negedge clk_in);
    start_in = 1'b1;
  endtask

  // runs cycles, acting as the assembler and recording what the DUT emits
  task automatic run_asm(input int max_cyc, input int err_line, input int busy_at, input int stop_line);
    int cyc, last_nl_cyc, last_nc_cyc;
    bit nl_pending, have_nc, stop;
    logic [7:0] exp_c;
    for (int i = 0; i < 4; i++) begin nl_cnt[i] = 0; nc_cnt[i] = 0; end
    wr_n = 0; first_gap = -1; max_cc0 = -1; char_mis = 0; overlap = 0; dist_bad = 0;
    last_char = 8'h00; nl_seq.delete(); timeout = 1'b0;
    cyc = 0; last_nl_cyc = 0; last_nc_cyc = 0; nl_pending = 1'b0; have_nc = 1'b0; stop = 1'b0;
    while (!stop && cyc < max_cyc) begin
      @(negedge clk_in);
      cyc++;
      start_in = 1'b0; asm_done_in = 1'b0; asm_error_in = 1'b0;
      if (cyc == busy_at) start_in = 1'b1;
      if (new_line) begin
        nl_seq.push_back(int'(line_count));
        nl_cnt[int'(assembler_state)]++;
        if (new_character) overlap++;
        if (have_nc && first_gap < 0) first_gap = cyc - last_nc_cyc;
        last_nl_cyc = cyc; nl_pending = 1'b1;
      end
      if (new_character) begin
        nc_cnt[int'(assembler_state)]++;
        last_char = incoming_character;
        if (line_count == 8'd0 && assembler_state == PC_MAPPING) max_cc0 = int'(char_count);
        exp_c = mem[{line_count, char_count}];
        if (exp_c == 8'h00) exp_c = 8'h0A;
        if (incoming_character !== exp_c) char_mis++;
        if (nl_pending) begin
          if (cyc - last_nl_cyc != RL + 2) dist_bad++;
          nl_pending = 1'b0;
        end
        last_nc_cyc = cyc; have_nc = 1'b1;
        if (incoming_character == 8'h0A && assembler_state == INSTRUCTION_MAPPING && has_instr[line_count]) begin
          asm_done_in = 1'b1;
          asm_instruction_in = instr_tab[line_count];
        end
        if (err_line >= 0 && assembler_state == INSTRUCTION_MAPPING && int'(line_count) == err_line && char_count == 6'd1)
          asm_error_in = 1'b1;
        if (stop_line >= 0 && assembler_state == INSTRUCTION_MAPPING && int'(line_count) == stop_line && char_count == 6'd2)
          stop = 1'b1;
      end
      if (imem_we_out) begin
        if (wr_n < 16) begin wr_addr[wr_n] = imem_addr_out; wr_data[wr_n] = imem_data_out; end
        wr_n++;
      end
      if (assembler_state == ASM_DONE || error_out) stop = 1'b1;
    end
    if (!stop) timeout = 1'b1;
    start_in = 1'b0; asm_done_in = 1'b0; asm_error_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    repeat (3) @(negedge clk_in);
    checks++;
    if ({new_line, new_character, line_count, char_count, incoming_character, text_addr_out} !== 42'd0) begin
      errors++; $display("FAIL reset_stream got %0h exp 0", {new_line, new_character, line_count, char_count, incoming_character, text_addr_out});
    end
    checks++;
    if ({imem_we_out, imem_addr_out, imem_data_out, inst_count_out} !== 50'd0) begin
      errors++; $display("FAIL reset_imem got %0h exp 0", {imem_we_out, imem_addr_out, imem_data_out, inst_count_out});
    end
    checks++;
    if ({busy_out, error_out, error_line_out} !== 10'd0 || assembler_state !== ASM_IDLE) begin
      errors++; $display("FAIL reset_status got %0h/%0d exp 0/ASM_IDLE", {busy_out, error_out, error_line_out}, assembler_state);
    end
    rst_in = 1'b1;
    @(negedge clk_in);
  endtask

  task automatic test_basic();
    clear_mem();
    load_line(0, "addi x1, x0, 5\n");
    has_instr[0] = 1'b1; instr_tab[0] = 32'h00500093;
    pulse_start();
    run_asm(5000, -1, -1, -1);
    checks++; if (timeout) begin errors++; $display("FAIL basic_timeout got timeout exp ASM_DONE"); end
    checks++; if (nc_cnt[1] !== 15 || nc_cnt[2] !== 15) begin errors++; $display("FAIL basic_chars got %0d/%0d exp 15/15", nc_cnt[1], nc_cnt[2]); end
    checks++; if (nl_cnt[1] !== 2 || nl_cnt[2] !== 2) begin errors++; $display("FAIL basic_lines got %0d/%0d exp 2/2", nl_cnt[1], nl_cnt[2]); end
    checks++; if (wr_n !== 1) begin errors++; $display("FAIL basic_wr_n got %0d exp 1", wr_n); end
    checks++; if (wr_addr[0] !== 8'd0 || wr_data[0] !== 32'h00500093) begin errors++; $display("FAIL basic_wr got %0h:%0h exp 0:00500093", wr_addr[0], wr_data[0]); end
    checks++; if (assembler_state !== ASM_DONE || busy_out !== 1'b0 || inst_count_out !== 9'd1) begin
      errors++; $display("FAIL basic_done got %0d/%0b/%0d exp ASM_DONE/0/1", assembler_state, busy_out, inst_count_out); end
    checks++; if (char_mis !== 0 || last_char !== 8'h0A) begin errors++; $display("FAIL basic_chars_val got %0d/%0h exp 0/0a", char_mis, last_char); end
    checks++; if (overlap !== 0 || dist_bad !== 0) begin errors++; $display("FAIL basic_timing got %0d/%0d exp 0/0", overlap, dist_bad); end
  endtask

  task automatic test_label();
    clear_mem();
    load_line(0, "loop:\n");
    load_line(1, "addi x1, x0, 5\n");
    has_instr[1] = 1'b1; instr_tab[1] = 32'h00500093;
    pulse_start();
    run_asm(5000, -1, -1, -1);
    checks++; if (timeout || nc_cnt[2] !== 21) begin errors++; $display("FAIL label_chars got %0d t=%0b exp 21", nc_cnt[2], timeout); end
    checks++; if (wr_n !== 1 || wr_addr[0] !== 8'd0 || wr_data[0] !== 32'h00500093) begin
      errors++; $display("FAIL label_wr got %0d %0h:%0h exp 1 0:00500093", wr_n, wr_addr[0], wr_data[0]); end
  endtask

  task automatic test_long_line();
    clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 8'h61;
    pulse_start();
    run_asm(5000, -1, -1, -1);
    checks++; if (timeout || nc_cnt[1] !== 64 || nc_cnt[2] !== 64) begin
      errors++; $display("FAIL long_chars got %0d/%0d t=%0b exp 64/64", nc_cnt[1], nc_cnt[2], timeout); end
    checks++; if (max_cc0 !== 63) begin errors++; $display("FAIL long_last_cc got %0d exp 63", max_cc0); end
    checks++; if (first_gap !== 5) begin errors++; $display("FAIL long_gap got %0d exp 5", first_gap); end
    checks++; if (char_mis !== 0 || wr_n !== 0) begin errors++; $display("FAIL long_data got %0d/%0d exp 0/0", char_mis, wr_n); end
  endtask

  task automatic test_error();
    int pulses;
    clear_mem();
    for (int i = 0; i < 5; i++) begin
      load_line(i, "nop\n");
      has_instr[i] = 1'b1; instr_tab[i] = 32'h00000013 + i;
    end
    pulse_start();
    run_asm(5000, 3, -1, -1);
    checks++; if (error_out !== 1'b1 || error_line_out !== 8'd3) begin
      errors++; $display("FAIL err_flag got %0b/%0d exp 1/3", error_out, error_line_out); end
    checks++; if (busy_out !== 1'b0 || assembler_state !== ASM_IDLE) begin
      errors++; $display("FAIL err_status got %0b/%0d exp 0/ASM_IDLE", busy_out, assembler_state); end
    checks++; if (wr_n !== 3 || wr_addr[2] !== 8'd2 || wr_data[2] !== 32'h00000015 || inst_count_out !== 9'd3) begin
      errors++; $display("FAIL err_writes got %0d %0h:%0h cnt %0d exp 3 2:00000015 cnt 3", wr_n, wr_addr[2], wr_data[2], inst_count_out); end
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_in);
      if (new_line || new_character || imem_we_out) pulses++;
    end
    checks++; if (pulses !== 0 || error_out !== 1'b1) begin errors++; $display("FAIL err_quiet got %0d/%0b exp 0/1", pulses, error_out); end
    pulse_start();
    @(negedge clk_in);
    start_in = 1'b0;
    checks++; if (error_out !== 1'b0 || error_line_out !== 8'd0 || inst_count_out !== 9'd0 || busy_out !== 1'b1 || assembler_state !== PC_MAPPING) begin
      errors++; $display("FAIL err_restart got %0b/%0d/%0d/%0b/%0d exp 0/0/0/1/PC_MAPPING", error_out, error_line_out, inst_count_out, busy_out, assembler_state); end
    run_asm(5000, -1, -1, -1);
    checks++; if (timeout || assembler_state !== ASM_DONE || wr_n !== 5 || inst_count_out !== 9'd5) begin
      errors++; $display("FAIL err_rerun got %0d wr %0d cnt %0d exp ASM_DONE 5 5", assembler_state, wr_n, inst_count_out); end
  endtask

  task automatic test_reset_mid();
    clear_mem();
    load_line(0, "addi x1, x0, 5\n");
    has_instr[0] = 1'b1; instr_tab[0] = 32'h00500093;
    pulse_start();
    run_asm(5000, -1, -1, 0);
    checks++; if (timeout || assembler_state !== INSTRUCTION_MAPPING) begin
      errors++; $display("FAIL rmid_reach got %0d t=%0b exp INSTRUCTION_MAPPING", assembler_state, timeout); end
    rst_in = 1'b0;
    @(negedge clk_in);
    checks++; if ({new_line, new_character, line_count, char_count, incoming_character, text_addr_out, imem_we_out,
                   imem_addr_out, imem_data_out, busy_out, error_out, error_line_out, inst_count_out} !== 102'd0 ||
                  assembler_state !== ASM_IDLE) begin
      errors++; $display("FAIL rmid_clear got %0h/%0d exp 0/ASM_IDLE", {line_count, char_count, incoming_character, text_addr_out, busy_out}, assembler_state); end
    rst_in = 1'b1;
    pulse_start();
    run_asm(5000, -1, -1, -1);
    checks++; if (timeout || assembler_state !== ASM_DONE || nc_cnt[1] !== 15 || nc_cnt[2] !== 15 || wr_n !== 1) begin
      errors++; $display("FAIL rmid_rerun got %0d %0d/%0d wr %0d exp ASM_DONE 15/15 1", assembler_state, nc_cnt[1], nc_cnt[2], wr_n); end
  endtask

  task automatic test_busy_start();
    int exp_seq [6];
    int bad;
    clear_mem();
    load_line(0, "loop:\n");
    load_line(1, "addi x1, x0, 5\n");
    has_instr[1] = 1'b1; instr_tab[1] = 32'h00500093;
    exp_seq = '{0, 1, 2, 0, 1, 2};
    pulse_start();
    run_asm(5000, -1, 12, -1);
    bad = (nl_seq.size() != 6) ? 1 : 0;
    for (int i = 0; i < 6 && i < nl_seq.size(); i++) if (nl_seq[i] != exp_seq[i]) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL busy_seq got %0d lines %0d bad exp 6 lines 0 bad", nl_seq.size(), bad); end
    checks++; if (timeout || wr_n !== 1 || inst_count_out !== 9'd1) begin
      errors++; $display("FAIL busy_wr got %0d cnt %0d exp 1 1", wr_n, inst_count_out); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_label();
    test_long_line();
    test_error();
    test_reset_mid();
    test_busy_start();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
